// File: rtl/dimmer_controller_if.sv
// Button/tick inputs and lamp/PWM outputs of the dimmer level controller.
interface dimmer_controller_if;
  logic       tick;
  logic       u;
  logic       d;
  logic [1:0] level;
  logic       A;
  logic       B;
  logic       C;
  logic       pwm;

  // Board/divisor side: drives buttons and tick, observes lamps.
  modport master (
    output tick,
    output u,
    output d,
    input  level,
    input  A,
    input  B,
    input  C,
    input  pwm
  );

  // Controller side.
  modport slave (
    input  tick,
    input  u,
    input  d,
    output level,
    output A,
    output B,
    output C,
    output pwm
  );
endinterface

// File: rtl/dimmer_controller.sv
// Dimmer level controller: button conditioning, saturating 4-level state,
// lamp decode and duty-cycled PWM enable.
module dimmer_controller #(
  parameter int unsigned PWM_BITS = 4
) (
  input logic                clk_in,
  input logic                reset,
  dimmer_controller_if.slave bus
);

  typedef enum logic [1:0] {
    OFF  = 2'd0,
    LOW  = 2'd1,
    MID  = 2'd2,
    HIGH = 2'd3
  } state_t;

  logic                u_meta;
  logic                u_sync;
  logic                d_meta;
  logic                d_sync;
  logic [1:0]          u_samp;
  logic [1:0]          d_samp;
  logic                u_db;
  logic                d_db;
  logic                u_db_q;
  logic                d_db_q;
  logic                press_u;
  logic                press_d;
  state_t              state;
  logic [PWM_BITS-1:0] pcnt;
  logic                pwm_q;

  // Two-flop synchronizers for the asynchronous buttons.
  always_ff @(posedge clk_in) begin
    if (reset) begin
      u_meta <= 1'b0;
      u_sync <= 1'b0;
      d_meta <= 1'b0;
      d_sync <= 1'b0;
    end else begin
      u_meta <= bus.u;
      u_sync <= u_meta;
      d_meta <= bus.d;
      d_sync <= d_meta;
    end
  end

  // Tick-paced sampling and debounce: two equal samples move db, mixed holds.
  always_ff @(posedge clk_in) begin
    if (reset) begin
      u_samp <= 2'b00;
      d_samp <= 2'b00;
      u_db   <= 1'b0;
      d_db   <= 1'b0;
      u_db_q <= 1'b0;
      d_db_q <= 1'b0;
    end else begin
      if (bus.tick) begin
        u_samp <= {u_samp[0], u_sync};
        d_samp <= {d_samp[0], d_sync};
      end
      if (u_samp == 2'b11) begin
        u_db <= 1'b1;
      end else if (u_samp == 2'b00) begin
        u_db <= 1'b0;
      end
      if (d_samp == 2'b11) begin
        d_db <= 1'b1;
      end else if (d_samp == 2'b00) begin
        d_db <= 1'b0;
      end
      u_db_q <= u_db;
      d_db_q <= d_db;
    end
  end

  // One-cycle pulse per debounced rising edge; releases produce nothing.
  assign press_u = u_db & ~u_db_q;
  assign press_d = d_db & ~d_db_q;

  // Saturating brightness state; simultaneous presses cancel.
  always_ff @(posedge clk_in) begin
    if (reset) begin
      state <= OFF;
    end else if (press_u && !press_d && state != HIGH) begin
      state <= state_t'(2'(state) + 2'd1);
    end else if (press_d && !press_u && state != OFF) begin
      state <= state_t'(2'(state) - 2'd1);
    end
  end

  // Free-running PWM counter; top two bits compared against level give level/4 duty.
  always_ff @(posedge clk_in) begin
    if (reset) begin
      pcnt  <= '0;
      pwm_q <= 1'b0;
    end else begin
      pcnt  <= pcnt + PWM_BITS'(1);
      pwm_q <= (pcnt[PWM_BITS-1 -: 2] < 2'(state));
    end
  end

  // Lamp enables decode the level register directly.
  assign bus.level = 2'(state);
  assign bus.A     = (state != OFF);
  assign bus.B     = state[1];
  assign bus.C     = (state == HIGH);
  assign bus.pwm   = pwm_q;

endmodule

// File: tb/tb_dimmer_controller.sv
// Scoreboard bench for dimmer_controller: button sequences, glitches,
// simultaneous presses, reset behaviour and PWM duty.
module tb_dimmer_controller;
  localparam int unsigned PWM_BITS = 4;

  logic clk_in = 1'b0;
  logic reset;

  dimmer_controller_if bus ();

  dimmer_controller #(.PWM_BITS(PWM_BITS)) dut (
    .clk_in (clk_in),
    .reset  (reset),
    .bus    (bus)
  );

  always #5 clk_in = ~clk_in;

  typedef struct {
    string       tag;
    logic [31:0] val;
  } exp_t;

  exp_t       exp_q[$];
  int         n_total = 0;
  int         n_bad   = 0;
  logic [1:0] model_lvl;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic sb_push(input string tag, input logic [31:0] val);
    exp_t e;
    e.tag = tag;
    e.val = val;
    exp_q.push_back(e);
  endtask

  task automatic sb_pop(input logic [31:0] got);
    exp_t e;
    if (exp_q.size() == 0) begin
      check("sb_underflow", 32'(exp_q.size()), 32'd1);
    end else begin
      e = exp_q.pop_front();
      check(e.tag, got, e.val);
    end
  endtask

  function automatic logic [1:0] next_level(input logic [1:0] cur, input logic up, input logic dn);
    if (up && !dn && cur != 2'd3) return cur + 2'd1;
    if (dn && !up && cur != 2'd0) return cur - 2'd1;
    return cur;
  endfunction

  // {level, A, B, C} expected for a given level
  function automatic logic [31:0] lamp_word(input logic [1:0] lvl);
    return {27'd0, lvl, (lvl >= 2'd1), (lvl >= 2'd2), (lvl == 2'd3)};
  endfunction

  function automatic logic [31:0] dut_word();
    return {27'd0, bus.level, bus.A, bus.B, bus.C};
  endfunction

  // One clock cycle with the given tick value; returns #1 after the edge.
  task automatic cycle(input logic t);
    bus.tick = t;
    @(posedge clk_in);
    #1;
    bus.tick = 1'b0;
  endtask

  task automatic tick_period();
    repeat (3) cycle(1'b0);
    cycle(1'b1);
  endtask

  // Clean press: held for 3 tick samples, released for 3.
  task automatic press(input logic pu, input logic pd, input string tag);
    model_lvl = next_level(model_lvl, pu, pd);
    sb_push(tag, lamp_word(model_lvl));
    bus.u = pu;
    bus.d = pd;
    repeat (3) tick_period();
    bus.u = 1'b0;
    bus.d = 1'b0;
    repeat (3) tick_period();
    sb_pop(dut_word());
  endtask

  task automatic pwm_count(input string tag, input int exp);
    int hi;
    hi = 0;
    sb_push(tag, 32'(exp));
    for (int i = 0; i < 16; i++) begin
      cycle(1'b0);
      if (bus.pwm) hi++;
    end
    sb_pop(32'(hi));
  endtask

  initial begin
    reset     = 1'b1;
    bus.u     = 1'b1;
    bus.d     = 1'b0;
    bus.tick  = 1'b0;
    model_lvl = 2'd0;

    // Reset held with u pressed and tick pulsing: everything stays dark.
    for (int i = 0; i < 12; i++) begin
      cycle(i % 4 == 3);
      sb_push("rst_hold", 32'd0);
      sb_pop({26'd0, bus.level, bus.A, bus.B, bus.C, bus.pwm});
    end

    // Release with u still held: two ticks pass before it counts as a fresh press.
    reset = 1'b0;
    for (int i = 0; i < 8; i++) begin
      cycle(i % 4 == 3);
      sb_push("post_rst", 32'd0);
      sb_pop({26'd0, bus.level, bus.A, bus.B, bus.C, bus.pwm});
    end
    cycle(1'b0);
    sb_push("post_rst_t2", lamp_word(2'd0));
    sb_pop(dut_word());
    cycle(1'b0);
    model_lvl = 2'd1;
    sb_push("post_rst_t3", lamp_word(model_lvl));
    sb_pop(dut_word());
    bus.u = 1'b0;
    repeat (3) tick_period();
    sb_push("post_rst_hold", lamp_word(model_lvl));
    sb_pop(dut_word());

    // Clean reset, then first up press with exact latency from the second tick.
    reset = 1'b1;
    repeat (2) cycle(1'b0);
    reset = 1'b0;
    model_lvl = 2'd0;
    cycle(1'b0);
    sb_push("rst2", lamp_word(model_lvl));
    sb_pop(dut_word());

    bus.u = 1'b1;
    tick_period();
    repeat (3) cycle(1'b0);
    cycle(1'b1);
    sb_push("lat_t1", lamp_word(2'd0));
    sb_pop(dut_word());
    cycle(1'b0);
    sb_push("lat_t2", lamp_word(2'd0));
    sb_pop(dut_word());
    cycle(1'b0);
    model_lvl = 2'd1;
    sb_push("lat_t3", lamp_word(model_lvl));
    sb_pop(dut_word());
    bus.u = 1'b0;
    repeat (3) tick_period();

    pwm_count("pwm_l1", 4);
    press(1'b1, 1'b0, "up2");
    press(1'b1, 1'b0, "up3");
    press(1'b1, 1'b0, "up_sat");
    pwm_count("pwm_l3", 12);

    press(1'b0, 1'b1, "dn2");
    pwm_count("pwm_l2", 8);
    press(1'b0, 1'b1, "dn1");
    press(1'b0, 1'b1, "dn0");
    press(1'b0, 1'b1, "dn_sat_a");
    press(1'b0, 1'b1, "dn_sat_b");
    pwm_count("pwm_l0", 0);

    press(1'b1, 1'b0, "up_to1");

    // Single-sample glitch.
    sb_push("glitch1", lamp_word(model_lvl));
    bus.u = 1'b1;
    tick_period();
    bus.u = 1'b0;
    repeat (3) tick_period();
    sb_pop(dut_word());

    // Bounce 1-0-1 across ticks.
    sb_push("bounce", lamp_word(model_lvl));
    bus.u = 1'b1;
    tick_period();
    bus.u = 1'b0;
    tick_period();
    bus.u = 1'b1;
    tick_period();
    bus.u = 1'b0;
    repeat (3) tick_period();
    sb_pop(dut_word());

    // Both buttons rising together cancel.
    press(1'b1, 1'b1, "simul");

    // Staggered by one tick: up lands first, then down.
    bus.u = 1'b1;
    tick_period();
    bus.d = 1'b1;
    tick_period();
    tick_period();
    sb_push("stag_mid", lamp_word(next_level(model_lvl, 1'b1, 1'b0)));
    sb_pop(dut_word());
    bus.u = 1'b0;
    tick_period();
    bus.d = 1'b0;
    repeat (3) tick_period();
    model_lvl = next_level(next_level(model_lvl, 1'b1, 1'b0), 1'b0, 1'b1);
    sb_push("stag_end", lamp_word(model_lvl));
    sb_pop(dut_word());

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
